// File: rtl/spi_tx_if.sv
// Byte-side handshake between a producer and the spi_tx serializer.
// A push happens on a clock edge where data_valid and data_ready are both high.
interface spi_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/spi_tx.sv
// FIFO-buffered byte serializer, LSB first, back-to-back bytes with no idle bit.
// Optional odd-parity output is enabled by defining SPI_TX_PARITY_EN.
module spi_tx #(
    parameter int   DEPTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spi_tx_if.slave                  bus,
    input  logic                     abort,
    output logic                     bit_out,
    output logic                     frame_start,
    output logic                     byte_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
`ifdef SPI_TX_PARITY_EN
    output logic                     parity_out,
`endif
    output logic                     flush_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    shreg;
    logic [7:0]    head;
    logic [2:0]    bcnt;
    logic          push;
    logic          pop;
    logic          go_idle;

    assign bus.data_ready = (fifo_count < CW'(DEPTH)) && !abort && rst_n;
    assign push    = bus.data_valid && bus.data_ready;
    // Pop only from registered count, so a freshly pushed byte waits one edge.
    assign pop     = !abort && (fifo_count != '0) &&
                     ((state == IDLE) || (bcnt == 3'd7));
    assign go_idle = !abort && (state == SHIFT) && (bcnt == 3'd7) &&
                     (fifo_count == '0);
    assign head    = mem[rd_ptr];

    // NOTE: FIFO storage has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_out     <= IDLE_BIT;
            frame_start <= 1'b0;
            byte_done   <= 1'b0;
            busy        <= 1'b0;
            fifo_count  <= '0;
            flush_out   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bcnt        <= '0;
            shreg       <= '0;
        end else begin
            flush_out <= abort;
            if (abort) begin
                state       <= IDLE;
                bit_out     <= IDLE_BIT;
                frame_start <= 1'b0;
                byte_done   <= 1'b0;
                busy        <= 1'b0;
                fifo_count  <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                bcnt        <= '0;
            end else begin
                wr_ptr     <= wr_ptr + AW'(push);
                rd_ptr     <= rd_ptr + AW'(pop);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (pop) begin
                    state       <= SHIFT;
                    shreg       <= head;
                    bit_out     <= head[0];
                    bcnt        <= 3'd0;
                    frame_start <= 1'b1;
                    byte_done   <= 1'b0;
                    busy        <= 1'b1;
                end else if (go_idle) begin
                    state       <= IDLE;
                    bit_out     <= IDLE_BIT;
                    frame_start <= 1'b0;
                    byte_done   <= 1'b0;
                    busy        <= 1'b0;
                end else if (state == SHIFT) begin
                    bit_out     <= shreg[bcnt + 3'd1];
                    bcnt        <= bcnt + 3'd1;
                    frame_start <= 1'b0;
                    byte_done   <= (bcnt == 3'd6);
                end
            end
        end
    end

`ifdef SPI_TX_PARITY_EN
    // Odd parity of the byte being shifted, captured when it is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_out <= 1'b0;
        end else if (abort || go_idle) begin
            parity_out <= 1'b0;
        end else if (pop) begin
            parity_out <= ~^head;
        end
    end
`endif
endmodule

// File: tb/tb_spi_tx.sv
// Directed self-checking bench for spi_tx with a byte-reassembling receiver model.
// Parity checks are included when SPI_TX_PARITY_EN is defined.
module tb_spi_tx;
    logic       clk;
    logic       rst_n;
    logic       abort;
    logic       bit_out;
    logic       frame_start;
    logic       byte_done;
    logic       busy;
    logic [2:0] fifo_count;
    logic       flush_out;
`ifdef SPI_TX_PARITY_EN
    logic       parity_out;
`endif

    spi_tx_if bus ();

    spi_tx #(.DEPTH(4), .IDLE_BIT(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .abort       (abort),
        .bit_out     (bit_out),
        .frame_start (frame_start),
        .byte_done   (byte_done),
        .busy        (busy),
        .fifo_count  (fifo_count),
`ifdef SPI_TX_PARITY_EN
        .parity_out  (parity_out),
`endif
        .flush_out   (flush_out)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] rx_shift;
    logic [7:0] rxq [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge, then run the downstream receiver model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (flush_out) rx_shift = 8'h00;
        if (busy) begin
            rx_shift = {bit_out, rx_shift[7:1]};
            if (byte_done) rxq.push_back(rx_shift);
        end
    endtask

    // Eight edges of one byte on the wire; optionally drop data_valid after the first.
    task automatic expect_byte(input string tag, input logic [7:0] b, input logic par,
                               input bit release_valid);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (release_valid && i == 0) bus.data_valid = 1'b0;
            check({tag, ".bit"}, bit_out, b[i]);
            check({tag, ".frame_start"}, frame_start, (i == 0));
            check({tag, ".byte_done"}, byte_done, (i == 7));
            check({tag, ".busy"}, busy, 1'b1);
`ifdef SPI_TX_PARITY_EN
            check({tag, ".parity"}, parity_out, par);
`else
            if (par === 1'bx) check({tag, ".par_arg"}, par, 1'b0);
`endif
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".idle_bit"}, bit_out, 1'b0);
        check({tag, ".idle_busy"}, busy, 1'b0);
        check({tag, ".idle_byte_done"}, byte_done, 1'b0);
`ifdef SPI_TX_PARITY_EN
        check({tag, ".idle_parity"}, parity_out, 1'b0);
`endif
    endtask

    initial begin
        logic [7:0] val;
        bit         hs;
        rst_n          = 1'b0;
        abort          = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        rx_shift       = 8'h00;

        // Reset state
        #3;
        check("rst.bit_out", bit_out, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.frame_start", frame_start, 1'b0);
        check("rst.byte_done", byte_done, 1'b0);
        check("rst.fifo_count", fifo_count, 3'd0);
        check("rst.flush_out", flush_out, 1'b0);
        check("rst.data_ready", bus.data_ready, 1'b0);
        #9 rst_n = 1'b1;
        #1;
        check("rst.ready_after", bus.data_ready, 1'b1);

        // Single byte 0x53: bits 1,1,0,0,1,0,1,0
        bus.data_in = 8'h53; bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        check("single.count", fifo_count, 3'd1);
        check("single.no_bypass", busy, 1'b0);
        expect_byte("single", 8'b0101_0011, 1'b1, 1'b0);
        tick();
        check_idle("single");
        check("single.rx_n", rxq.size(), 1);
        if (rxq.size() >= 1) check("single.rx", rxq[0], 8'h53);
        rxq.delete();

        // Back-to-back 0x53, 0xFC
        bus.data_in = 8'h53; bus.data_valid = 1'b1;
        tick();
        bus.data_in = 8'hFC;
        expect_byte("b2b0", 8'h53, 1'b1, 1'b1);
        expect_byte("b2b1", 8'hFC, 1'b1, 1'b0);
        tick();
        check_idle("b2b");
        check("b2b.rx_n", rxq.size(), 2);
        if (rxq.size() >= 2) begin
            check("b2b.rx0", rxq[0], 8'h53);
            check("b2b.rx1", rxq[1], 8'hFC);
        end
        rxq.delete();

        // Full FIFO: offer 0x01..0x06 continuously
        val = 8'h01;
        bus.data_in = val; bus.data_valid = 1'b1;
        for (int cyc = 0; cyc < 150; cyc++) begin
            hs = bus.data_valid && bus.data_ready;
            tick();
            if (hs) begin
                if (val == 8'h06) bus.data_valid = 1'b0;
                else begin val = val + 8'h01; bus.data_in = val; end
            end
            if (cyc == 4) begin
                check("full.count", fifo_count, 3'd4);
                check("full.ready", bus.data_ready, 1'b0);
            end
            if (rxq.size() == 6 && !bus.data_valid) break;
        end
        check("full.rx_n", rxq.size(), 6);
        for (int i = 0; i < rxq.size() && i < 6; i++)
            check("full.rx", rxq[i], i + 1);
        tick(); tick();
        check_idle("full");
        rxq.delete();

        // Abort after three bits of 0xA5 with 0x3C queued
        bus.data_in = 8'hA5; bus.data_valid = 1'b1;
        tick();
        bus.data_in = 8'h3C;
        tick();
        bus.data_valid = 1'b0;
        check("abort.b0", bit_out, 1'b1);
        tick();
        check("abort.b1", bit_out, 1'b0);
        tick();
        check("abort.b2", bit_out, 1'b1);
        check("abort.queued", fifo_count, 3'd1);
        abort = 1'b1;
        bus.data_in = 8'h99; bus.data_valid = 1'b1;
        #1;
        check("abort.ready_low", bus.data_ready, 1'b0);
        tick();
        abort = 1'b0;
        bus.data_valid = 1'b0;
        check("abort.bit_out", bit_out, 1'b0);
        check("abort.count", fifo_count, 3'd0);
        check("abort.busy", busy, 1'b0);
        check("abort.flush", flush_out, 1'b1);
        tick();
        check("abort.flush_1cyc", flush_out, 1'b0);
        check("abort.stays_idle", busy, 1'b0);
        bus.data_in = 8'hE5; bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        for (int cyc = 0; cyc < 30 && rxq.size() == 0; cyc++) tick();
        check("abort.rx_n", rxq.size(), 1);
        if (rxq.size() >= 1) check("abort.rx", rxq[0], 8'hE5);
        tick(); tick();
        check("abort.rx_n_end", rxq.size(), 1);
        rxq.delete();

        // Asynchronous reset mid-shift with a byte still queued
        bus.data_in = 8'h0F; bus.data_valid = 1'b1;
        tick();
        bus.data_in = 8'h77;
        tick();
        bus.data_valid = 1'b0;
        tick();
        check("areset.pre_count", fifo_count, 3'd1);
        check("areset.pre_busy", busy, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("areset.busy", busy, 1'b0);
        check("areset.bit_out", bit_out, 1'b0);
        check("areset.count", fifo_count, 3'd0);
        check("areset.frame_start", frame_start, 1'b0);
        check("areset.ready", bus.data_ready, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        rx_shift = 8'h00;
        rxq.delete();
        bus.data_in = 8'h0F; bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        expect_byte("areset", 8'b0000_1111, 1'b1, 1'b0);
        tick();
        check_idle("areset");
        check("areset.rx_n", rxq.size(), 1);
        rxq.delete();

`ifdef SPI_TX_PARITY_EN
        // Parity of 0xFF then 0x01
        bus.data_in = 8'hFF; bus.data_valid = 1'b1;
        tick();
        bus.data_in = 8'h01;
        expect_byte("par_ff", 8'hFF, 1'b1, 1'b1);
        expect_byte("par_01", 8'h01, 1'b0, 1'b0);
        tick();
        check_idle("par");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
